// File: rtl/ect_frame_sequencer_pkg.sv
// Shared types and constants for the ECT frame sequencer: state codes, scan mode,
// bus widths and the measurements-per-frame derivation.
package ect_frame_sequencer_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned IDX_W = 10;

  localparam logic [DAT_W-1:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CONV   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STORE  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_TWIN   = 1'b1
  } mode_t;

  // Independent electrode pairs in one frame.
  function automatic int unsigned nmeas(input int unsigned nelec);
    return nelec * (nelec - 1) / 2;
  endfunction

endpackage

// File: rtl/ect_frame_sequencer_if.sv
// ADC conversion handshake between the frame sequencer (master) and the converter (slave).
interface ect_frame_sequencer_if;
  import ect_frame_sequencer_pkg::*;

  logic             AdcStart;
  logic             AdcDone;
  logic [DAT_W-1:0] AdcDat;

  modport master (output AdcStart, input AdcDone, input AdcDat);
  modport slave  (input AdcStart, output AdcDone, output AdcDat);
endinterface

// File: rtl/ect_frame_sequencer_pair_counter.sv
// Excitation/detection index generator: walks pairs (i,j) with j > i, j fastest.
module ect_frame_sequencer_pair_counter
  import ect_frame_sequencer_pkg::*;
#(
  parameter int unsigned NELEC = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             advance,
  output logic [SEL_W-1:0] exc,
  output logic [SEL_W-1:0] det,
  output logic             last
);

  logic [SEL_W-1:0] exc_n;
  logic [SEL_W-1:0] det_n;

  always_comb begin
    exc_n = exc;
    det_n = det;
    if (init) begin
      exc_n = '0;
      det_n = SEL_W'(1);
    end else if (advance) begin
      if (det == SEL_W'(NELEC - 1)) begin
        exc_n = exc + SEL_W'(1);
        det_n = exc + SEL_W'(2);
      end else begin
        det_n = det + SEL_W'(1);
      end
    end
  end

  // last is registered from the next-pair value so it is valid with the selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc  <= '0;
      det  <= SEL_W'(1);
      last <= (NELEC == 2);
    end else begin
      exc  <= exc_n;
      det  <= det_n;
      last <= (exc_n == SEL_W'(NELEC - 2)) && (det_n == SEL_W'(NELEC - 1));
    end
  end

endmodule

// File: rtl/ect_frame_sequencer.sv
// ECT frame sequencer: scans all electrode pairs, settles, runs one ADC conversion
// per pair, emits samples and signals frame end (single or continuous mode).
module ect_frame_sequencer
  import ect_frame_sequencer_pkg::*;
#(
  parameter int unsigned NELEC   = 12,
  parameter int unsigned SETTLE  = 200,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 EnSingle,
  input  logic                 EnTwin,
  ect_frame_sequencer_if.master adc,
  output logic [SEL_W-1:0]     ExcSel,
  output logic [SEL_W-1:0]     DetSel,
  output logic [DAT_W-1:0]     MeasDat,
  output logic [IDX_W-1:0]     MeasIdx,
  output logic                 MeasValid,
  output logic                 FrameEnd,
  output logic                 Busy,
  output logic                 AdcErr,
  output logic [2:0]           Stat
);

  localparam int unsigned NMEAS  = nmeas(NELEC);
  localparam int unsigned CNT_W  = $clog2(SETTLE + 1);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NMEAS - 1);

  state_t             state;
  mode_t              mode;
  logic               en_single_q;
  logic               en_twin_q;
  logic [CNT_W-1:0]   settle_cnt;
  logic [TCNT_W-1:0]  wait_cnt;
  logic               adc_start;
  logic               meas_valid;
  logic               frame_end;
  logic               busy;
  logic               adc_err;
  logic [DAT_W-1:0]   meas_dat;
  logic [IDX_W-1:0]   meas_idx;
  logic               pair_last;

  logic mode_en_c, abort_c, single_edge_c, twin_edge_c, start_c, restart_c;

  assign single_edge_c = EnSingle && !en_single_q;
  assign twin_edge_c   = EnTwin && !en_twin_q;
  assign start_c       = (state == ST_IDLE) && (single_edge_c || twin_edge_c);
  assign mode_en_c     = (mode == MODE_TWIN) ? EnTwin : EnSingle;
  // Dropping the active enable wins over every other transition
  assign abort_c       = (state != ST_IDLE) && !mode_en_c;
  assign restart_c     = (state == ST_DONE) && (mode == MODE_TWIN) && !abort_c;

  ect_frame_sequencer_pair_counter #(.NELEC(NELEC)) u_pair (
    .clk     (Clk),
    .rst_n   (Rst),
    .init    (start_c || restart_c || abort_c),
    .advance ((state == ST_NEXT) && !abort_c),
    .exc     (ExcSel),
    .det     (DetSel),
    .last    (pair_last)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= ST_IDLE;
      mode        <= MODE_SINGLE;
      en_single_q <= 1'b0;
      en_twin_q   <= 1'b0;
      settle_cnt  <= '0;
      wait_cnt    <= '0;
      adc_start   <= 1'b0;
      meas_valid  <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
      adc_err     <= 1'b0;
      meas_dat    <= '0;
      meas_idx    <= '0;
    end else begin
      en_single_q <= EnSingle;
      en_twin_q   <= EnTwin;
      adc_start   <= 1'b0;
      meas_valid  <= 1'b0;
      frame_end   <= 1'b0;
      if (abort_c) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start_c) begin
            mode       <= twin_edge_c ? MODE_TWIN : MODE_SINGLE;
            adc_err    <= 1'b0;
            meas_idx   <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_cnt == CNT_W'(SETTLE - 1)) begin
              adc_start <= 1'b1;
              state     <= ST_CONV;
            end else begin
              settle_cnt <= settle_cnt + CNT_W'(1);
            end
          end
          ST_CONV: begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (adc.AdcDone) begin
              meas_dat   <= adc.AdcDat;
              meas_valid <= 1'b1;
              state      <= ST_STORE;
            end else if (wait_cnt == TCNT_W'(TIMEOUT - 1)) begin
              meas_dat   <= TIMEOUT_DATA;
              adc_err    <= 1'b1;
              meas_valid <= 1'b1;
              state      <= ST_STORE;
            end else begin
              wait_cnt <= wait_cnt + TCNT_W'(1);
            end
          end
          ST_STORE: begin
            if ((meas_idx == IDX_LAST) && pair_last) begin
              frame_end <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            meas_idx   <= meas_idx + IDX_W'(1);
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
          ST_DONE: begin
            if (restart_c) begin
              meas_idx   <= '0;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign adc.AdcStart = adc_start;
  assign MeasDat      = meas_dat;
  assign MeasIdx      = meas_idx;
  assign MeasValid    = meas_valid;
  assign FrameEnd     = frame_end;
  assign Busy         = busy;
  assign AdcErr       = adc_err;
  assign Stat         = state;

endmodule

// File: tb/tb_ect_frame_sequencer.sv
// Directed bench for ect_frame_sequencer (NELEC=4) with an ADC responder and a
// scoreboard of expected samples.
module tb_ect_frame_sequencer;

  localparam int NEL = 4;
  localparam int NM  = 6;
  localparam int LAT = 5;

  logic        Clk, Rst, EnSingle, EnTwin;
  logic [3:0]  ExcSel, DetSel;
  logic [15:0] MeasDat;
  logic [9:0]  MeasIdx;
  logic        MeasValid, FrameEnd, Busy, AdcErr;
  logic [2:0]  Stat;

  ect_frame_sequencer_if adc();

  ect_frame_sequencer #(.NELEC(NEL), .SETTLE(3), .TIMEOUT(8)) dut (
    .Clk(Clk), .Rst(Rst), .EnSingle(EnSingle), .EnTwin(EnTwin), .adc(adc),
    .ExcSel(ExcSel), .DetSel(DetSel), .MeasDat(MeasDat), .MeasIdx(MeasIdx),
    .MeasValid(MeasValid), .FrameEnd(FrameEnd), .Busy(Busy), .AdcErr(AdcErr),
    .Stat(Stat)
  );

  typedef struct {
    logic [9:0]  idx;
    logic [3:0]  exc;
    logic [3:0]  det;
    logic [15:0] dat;
  } exp_t;

  exp_t sb[$];
  logic [3:0] exc_tab [NM] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2};
  logic [3:0] det_tab [NM] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 4'd3};

  int vectors = 0, miscompares = 0;
  int mv_cnt = 0, fe_cnt = 0, cyc = 0, last_mv_cyc = -10;
  int adc_cnt = 0, conv_num = 0, drop_idx = -1;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ADC responder: answers LAT cycles after AdcStart, or stays silent for drop_idx
  initial begin : adc_model
    adc.AdcDone = 1'b0;
    adc.AdcDat  = '0;
    forever begin
      @(negedge Clk);
      adc.AdcDone = 1'b0;
      if (adc_cnt > 0) begin
        int k;
        exp_t e;
        adc_cnt--;
        if (adc_cnt == 0) begin
          k = conv_num % NM;
          e.idx = 10'(k);
          e.exc = exc_tab[k];
          e.det = det_tab[k];
          if (conv_num == drop_idx) begin
            e.dat = 16'hFFFF;
          end else begin
            e.dat = 16'(k) + 16'h0100;
            adc.AdcDone = 1'b1;
            adc.AdcDat  = e.dat;
          end
          sb.push_back(e);
          conv_num++;
        end
      end
      if (adc.AdcStart) adc_cnt = LAT;
    end
  end

  // Output monitor: pops the scoreboard on every MeasValid
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (MeasValid) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("meas_idx", 32'(MeasIdx), 32'(e.idx));
          check("meas_dat", 32'(MeasDat), 32'(e.dat));
          check("exc_sel", 32'(ExcSel), 32'(e.exc));
          check("det_sel", 32'(DetSel), 32'(e.det));
          if (e.idx == 10'(NM - 1)) last_mv_cyc = cyc;
        end
        mv_cnt++;
      end
      if (FrameEnd) begin
        fe_cnt++;
        check("frame_end_lat", 32'(cyc), 32'(last_mv_cyc + 1));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic wait_mv(input int n, input int budget);
    int b = budget;
    while (mv_cnt < n && b > 0) begin step(1); b--; end
  endtask

  task automatic wait_fe(input int n, input int budget);
    int b = budget;
    while (fe_cnt < n && b > 0) begin step(1); b--; end
  endtask

  initial begin : main
    Rst = 1'b0; EnSingle = 1'b0; EnTwin = 1'b0;
    step(2);
    check("rst_exc", 32'(ExcSel), 32'd0);
    check("rst_det", 32'(DetSel), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_stat", 32'(Stat), 32'd0);
    check("rst_outs", {MeasDat, 6'd0, MeasIdx}, 32'd0);
    check("rst_strobes", {28'd0, MeasValid, FrameEnd, AdcErr, adc.AdcStart}, 32'd0);
    Rst = 1'b1;
    step(2);

    // single frame
    conv_num = 0; EnSingle = 1'b1;
    step(1);
    check("start_stat", 32'(Stat), 32'd1);
    check("start_busy", 32'(Busy), 32'd1);
    wait_fe(1, 300);
    step(1);
    check("single_idle", 32'(Stat), 32'd0);
    check("single_mv", 32'(mv_cnt), 32'd6);
    check("single_fe", 32'(fe_cnt), 32'd1);

    // held enable does not retrigger; re-edge gives a second frame
    step(30);
    check("held_no_retrig", 32'(mv_cnt), 32'd6);
    check("held_busy", 32'(Busy), 32'd0);
    EnSingle = 1'b0;
    step(2);
    conv_num = 0; EnSingle = 1'b1;
    wait_fe(2, 300);
    step(1);
    check("second_mv", 32'(mv_cnt), 32'd12);
    check("second_idle", 32'(Busy), 32'd0);
    EnSingle = 1'b0;
    step(2);

    // continuous frames, abort mid third frame
    conv_num = 0; EnTwin = 1'b1;
    wait_mv(27, 600);
    check("twin_mv_reach", 32'(mv_cnt), 32'd27);
    EnTwin = 1'b0;
    step(1);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_stat", 32'(Stat), 32'd0);
    check("abort_sel", {24'd0, ExcSel, DetSel}, 32'h01);
    step(30);
    check("twin_fe", 32'(fe_cnt), 32'd4);
    check("twin_mv_after", 32'(mv_cnt), 32'd27);

    // stop emulation: drop enable in the cycle after FrameEnd
    conv_num = 0; EnTwin = 1'b1;
    wait_fe(5, 300);
    check("stop_fe_pulse", 32'(FrameEnd), 32'd1);
    step(1);
    EnTwin = 1'b0;
    step(1);
    check("stop_idle", 32'(Busy), 32'd0);
    step(30);
    check("stop_fe", 32'(fe_cnt), 32'd5);
    check("stop_mv", 32'(mv_cnt), 32'd33);

    // ADC timeout on measurement 2
    drop_idx = 2; conv_num = 0; EnSingle = 1'b1;
    wait_fe(6, 300);
    step(1);
    drop_idx = -1;
    check("to_err", 32'(AdcErr), 32'd1);
    check("to_mv", 32'(mv_cnt), 32'd39);
    EnSingle = 1'b0;
    step(2);
    check("to_err_sticky", 32'(AdcErr), 32'd1);
    conv_num = 0; EnSingle = 1'b1;
    step(1);
    check("to_err_clear", 32'(AdcErr), 32'd0);

    // reset while waiting for the ADC
    begin
      int b = 50;
      while (Stat != 3'd3 && b > 0) begin step(1); b--; end
    end
    check("reach_wait", 32'(Stat), 32'd3);
    Rst = 1'b0; adc_cnt = 0; EnSingle = 1'b0;
    #1;
    check("rst_wait_busy", 32'(Busy), 32'd0);
    check("rst_wait_stat", 32'(Stat), 32'd0);
    check("rst_wait_sel", {24'd0, ExcSel, DetSel}, 32'h01);
    check("rst_wait_start", 32'(adc.AdcStart), 32'd0);
    step(2);
    Rst = 1'b1;
    step(30);
    check("post_rst_busy", 32'(Busy), 32'd0);
    check("post_rst_mv", 32'(mv_cnt), 32'd39);
    check("post_rst_fe", 32'(fe_cnt), 32'd6);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
